// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter / fill sequencer slice.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    WRITE  = 2'd3
  } arb_state_e;

  localparam int unsigned BLOCK_WORDS_DEF = 8;
  localparam int unsigned MEM_LAT_DEF     = 4;
  localparam int unsigned IDX_W           = $clog2(BLOCK_WORDS_DEF);

  function automatic logic is_fill(input arb_state_e s);
    return (s == FILL_I) || (s == FILL_D);
  endfunction

endpackage

// File: rtl/mem_arbiter_fill_sequencer.sv
// Block fill sequencer: issue/receive word counters and block address generation.
module fill_sequencer #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [ADDR_W-1:0]              addr_i,
  input  logic                           active_i,
  input  logic                           data_valid_i,
  output logic [ADDR_W-1:0]              rd_addr_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] recv_idx_o,
  output logic                           issue_done_o,
  output logic                           last_word_o
);

  localparam int unsigned IW    = $clog2(BLOCK_WORDS);
  localparam int unsigned LOW_W = IW + 1;
  localparam logic [IW-1:0]     LAST     = IW'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((32'd1 << LOW_W) - 32'd1);

  logic [IW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [IW-1:0]     recv_cnt_q, recv_cnt_d;
  logic              issuing_q, issuing_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              recv_fire;

  assign recv_fire = active_i && data_valid_i;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    issuing_d   = issuing_q;
    base_d      = base_q;
    if (start_i) begin
      base_d      = addr_i & ~LOW_MASK;
      issuing_d   = 1'b1;
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
    end else begin
      if (issuing_q) begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LAST) issuing_d = 1'b0;
      end
      if (recv_fire) recv_cnt_d = recv_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      issuing_q   <= 1'b0;
      base_q      <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      issuing_q   <= issuing_d;
      base_q      <= base_d;
    end
  end

  // Base has its low bits cleared, so OR-ing in the word offset equals concatenation.
  assign rd_addr_o    = base_q | ADDR_W'({issue_cnt_q, 1'b0});
  assign recv_idx_o   = recv_cnt_q;
  assign issue_done_o = !issuing_q;
  assign last_word_o  = recv_fire && (recv_cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// I/D cache miss arbiter and fill sequencer for the shared pipelined memory.
// Define ARB_ROUND_ROBIN_EN to alternate grants between simultaneous I and D misses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int unsigned MEM_LAT     = MEM_LAT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_req,
  input  logic [ADDR_W-1:0]              i_addr,
  input  logic                           d_req,
  input  logic [ADDR_W-1:0]              d_addr,
  input  logic                           d_wr_req,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [DATA_W-1:0]              d_wr_data,
  output logic [DATA_W-1:0]              fill_data,
  output logic                           i_fill_valid,
  output logic                           d_fill_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
  output logic                           i_done,
  output logic                           d_done,
  output logic                           d_wr_ack,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_data_in,
  input  logic [DATA_W-1:0]              mem_data_out,
  input  logic                           mem_data_valid,
  output logic                           busy
);

  localparam int unsigned IW = $clog2(BLOCK_WORDS);

  if ((MEM_LAT < 1) || (BLOCK_WORDS < 2) || ((1 << IW) != BLOCK_WORDS)) begin : g_cfg_check
    $error("mem_arbiter: MEM_LAT must be >= 1 and BLOCK_WORDS a power of 2 >= 2");
  end

  arb_state_e        state_q, state_d;
  logic              pick_d;
  logic              fill_start;
  logic [ADDR_W-1:0] fill_addr;
  logic              in_fill;
  logic [ADDR_W-1:0] rd_addr;
  logic [IW-1:0]     recv_idx;
  logic              issue_done;
  logic              last_word;

  assign in_fill = is_fill(state_q);

`ifdef ARB_ROUND_ROBIN_EN
  // last_d_q: 1 when the most recently completed fill served the D side.
  logic last_d_q, last_d_d;

  assign pick_d = d_req && !(i_req && last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if (in_fill && last_word) last_d_d = (state_q == FILL_D);
  end

  always_ff @(posedge clk) begin
    if (rst) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  end
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    fill_start = 1'b0;
    fill_addr  = i_addr;
    case (state_q)
      IDLE: begin
        if (d_wr_req) begin
          state_d = WRITE;
        end else if (pick_d) begin
          state_d    = FILL_D;
          fill_start = 1'b1;
          fill_addr  = d_addr;
        end else if (i_req) begin
          state_d    = FILL_I;
          fill_start = 1'b1;
        end
      end
      FILL_I, FILL_D: if (last_word) state_d = IDLE;
      WRITE:          state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  fill_sequencer #(
    .ADDR_W      (ADDR_W),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_fill_seq (
    .clk          (clk),
    .rst          (rst),
    .start_i      (fill_start),
    .addr_i       (fill_addr),
    .active_i     (in_fill),
    .data_valid_i (mem_data_valid),
    .rd_addr_o    (rd_addr),
    .recv_idx_o   (recv_idx),
    .issue_done_o (issue_done),
    .last_word_o  (last_word)
  );

  // Outputs are forced low while rst is high so the reset cycle itself is quiet.
  always_comb begin
    fill_data    = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    fill_idx     = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    d_wr_ack     = 1'b0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    busy         = 1'b0;
    if (!rst) begin
      busy = (state_q != IDLE);
      case (state_q)
        FILL_I, FILL_D: begin
          if (!issue_done) begin
            mem_enable = 1'b1;
            mem_addr   = rd_addr;
          end
          if (mem_data_valid) begin
            fill_data    = mem_data_out;
            fill_idx     = recv_idx;
            i_fill_valid = (state_q == FILL_I);
            d_fill_valid = (state_q == FILL_D);
          end
          i_done = last_word && (state_q == FILL_I);
          d_done = last_word && (state_q == FILL_D);
        end
        WRITE: begin
          mem_enable  = 1'b1;
          mem_wr      = 1'b1;
          mem_addr    = d_wr_addr;
          mem_data_in = d_wr_data;
          d_wr_ack    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 4-cycle pipelined memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic [15:0] fill_data, mem_addr, mem_data_in, mem_data_out;
  logic        i_fill_valid, d_fill_valid, i_done, d_done, d_wr_ack;
  logic        mem_enable, mem_wr, mem_data_valid, busy;
  logic [2:0]  fill_idx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .BLOCK_WORDS (8),
    .MEM_LAT     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .d_req          (d_req),
    .d_addr         (d_addr),
    .d_wr_req       (d_wr_req),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .fill_data      (fill_data),
    .i_fill_valid   (i_fill_valid),
    .d_fill_valid   (d_fill_valid),
    .fill_idx       (fill_idx),
    .i_done         (i_done),
    .d_done         (d_done),
    .d_wr_ack       (d_wr_ack),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid),
    .busy           (busy)
  );

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  // Memory: a read issued in cycle c returns in cycle c+4.
  logic [15:0] pa [4];
  logic        pv [4];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
      end
    end else begin
      pv[0] <= mem_enable && !mem_wr;
      pa[0] <= mem_addr;
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  assign mem_data_valid = pv[3];
  assign mem_data_out   = pv[3] ? mdata(pa[3]) : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " busy"},         32'(busy),         32'h0);
    chk({tag, " mem_enable"},   32'(mem_enable),   32'h0);
    chk({tag, " mem_wr"},       32'(mem_wr),       32'h0);
    chk({tag, " mem_addr"},     32'(mem_addr),     32'h0);
    chk({tag, " mem_data_in"},  32'(mem_data_in),  32'h0);
    chk({tag, " i_fill_valid"}, 32'(i_fill_valid), 32'h0);
    chk({tag, " d_fill_valid"}, 32'(d_fill_valid), 32'h0);
    chk({tag, " fill_data"},    32'(fill_data),    32'h0);
    chk({tag, " fill_idx"},     32'(fill_idx),     32'h0);
    chk({tag, " i_done"},       32'(i_done),       32'h0);
    chk({tag, " d_done"},       32'(d_done),       32'h0);
    chk({tag, " d_wr_ack"},     32'(d_wr_ack),     32'h0);
  endtask

  // Entered at cycle 0 with the request already driven; returns after checking cycle 12.
  task automatic run_fill(input bit is_d, input logic [15:0] base, input int wr_at);
    logic        en, v;
    logic [15:0] ea, ed;
    logic [2:0]  ei;
    string       t;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == wr_at) d_wr_req = 1'b1;
      #1;
      t  = $sformatf("%s@%04h c%0d", is_d ? "D" : "I", base, c);
      en = (c <= 8);
      v  = (c >= 5);
      ea = en ? base + 16'(2 * (c - 1)) : 16'h0000;
      ei = v ? 3'(c - 5) : 3'd0;
      ed = v ? mdata(base + 16'(2 * (c - 5))) : 16'h0000;
      chk({t, " mem_enable"},   32'(mem_enable),   32'(en));
      chk({t, " mem_wr"},       32'(mem_wr),       32'h0);
      chk({t, " mem_addr"},     32'(mem_addr),     32'(ea));
      chk({t, " mem_data_in"},  32'(mem_data_in),  32'h0);
      chk({t, " i_fill_valid"}, 32'(i_fill_valid), 32'(v && !is_d));
      chk({t, " d_fill_valid"}, 32'(d_fill_valid), 32'(v && is_d));
      chk({t, " fill_idx"},     32'(fill_idx),     32'(ei));
      chk({t, " fill_data"},    32'(fill_data),    32'(ed));
      chk({t, " i_done"},       32'(i_done),       32'(c == 12 && !is_d));
      chk({t, " d_done"},       32'(d_done),       32'(c == 12 && is_d));
      chk({t, " busy"},         32'(busy),         32'h1);
      chk({t, " d_wr_ack"},     32'(d_wr_ack),     32'h0);
    end
  endtask

  bit exp_d [4];

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset cycles and the cycle after
    repeat (2) @(negedge clk);
    #1 chk_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 chk_quiet("post_reset");

    // Lone I miss
    i_req = 1'b1;
    i_addr = 16'h0046;
    run_fill(1'b0, 16'h0040, 0);
    @(negedge clk);
    i_req = 1'b0;
    #1 chk("lone_i c13 busy", 32'(busy), 32'h0);

    // Single write
    @(negedge clk);
    d_wr_req = 1'b1;
    d_wr_addr = 16'h1234;
    d_wr_data = 16'hBEEF;
    #1 chk("wr c0 d_wr_ack", 32'(d_wr_ack), 32'h0);
    @(negedge clk);
    #1;
    chk("wr c1 mem_enable",  32'(mem_enable),  32'h1);
    chk("wr c1 mem_wr",      32'(mem_wr),      32'h1);
    chk("wr c1 d_wr_ack",    32'(d_wr_ack),    32'h1);
    chk("wr c1 mem_addr",    32'(mem_addr),    32'h1234);
    chk("wr c1 mem_data_in", 32'(mem_data_in), 32'hBEEF);
    chk("wr c1 busy",        32'(busy),        32'h1);
    @(negedge clk);
    d_wr_req = 1'b0;
    #1 chk_quiet("wr c2");

    // Simultaneous D and I miss: D first
    @(negedge clk);
    d_req = 1'b1;
    i_req = 1'b1;
    d_addr = 16'h2016;
    i_addr = 16'h3008;
    run_fill(1'b1, 16'h2010, 0);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("sim c13 busy",       32'(busy),       32'h0);
    chk("sim c13 mem_enable", 32'(mem_enable), 32'h0);
    run_fill(1'b0, 16'h3000, 0);
    @(negedge clk);
    i_req = 1'b0;
    #1 chk("sim c26 busy", 32'(busy), 32'h0);

    // Four back-to-back fills with both misses held
    @(negedge clk);
    d_req = 1'b1;
    i_req = 1'b1;
    d_addr = 16'h0A00;
    i_addr = 16'h0B1E;
    for (int k = 0; k < 4; k++) begin
      run_fill(exp_d[k], exp_d[k] ? 16'h0A00 : 16'h0B10, 0);
      @(negedge clk);
      if (k == 3) begin
        d_req = 1'b0;
        i_req = 1'b0;
      end
      #1 chk($sformatf("b2b gap%0d busy", k), 32'(busy), 32'h0);
    end

    // Write request raised mid I fill waits for i_done + 2
    @(negedge clk);
    i_req = 1'b1;
    i_addr = 16'h0100;
    d_wr_addr = 16'h0A0A;
    d_wr_data = 16'h1357;
    run_fill(1'b0, 16'h0100, 3);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("wrmid c13 busy",     32'(busy),     32'h0);
    chk("wrmid c13 d_wr_ack", 32'(d_wr_ack), 32'h0);
    @(negedge clk);
    #1;
    chk("wrmid c14 d_wr_ack",    32'(d_wr_ack),    32'h1);
    chk("wrmid c14 mem_wr",      32'(mem_wr),      32'h1);
    chk("wrmid c14 mem_enable",  32'(mem_enable),  32'h1);
    chk("wrmid c14 mem_addr",    32'(mem_addr),    32'h0A0A);
    chk("wrmid c14 mem_data_in", 32'(mem_data_in), 32'h1357);
    @(negedge clk);
    d_wr_req = 1'b0;
    #1 chk_quiet("wrmid c15");

    // Reset in cycle 6 of an I fill
    @(negedge clk);
    i_req = 1'b1;
    i_addr = 16'h0520;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      #1;
      if (c == 5) chk("rstmid c5 i_fill_valid", 32'(i_fill_valid), 32'h1);
    end
    @(negedge clk);
    rst = 1'b1;
    i_req = 1'b0;
    #1 chk_quiet("rstmid c6");
    @(negedge clk);
    rst = 1'b0;
    #1 chk_quiet("rstmid c7");
    for (int c = 8; c <= 14; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rstmid c%0d i_done", c),       32'(i_done),       32'h0);
      chk($sformatf("rstmid c%0d i_fill_valid", c), 32'(i_fill_valid), 32'h0);
      chk($sformatf("rstmid c%0d busy", c),         32'(busy),         32'h0);
    end

    // Clean fill after the abandoned one
    @(negedge clk);
    i_req = 1'b1;
    i_addr = 16'h7FFE;
    run_fill(1'b0, 16'h7FF0, 0);
    @(negedge clk);
    i_req = 1'b0;
    #1 chk("clean c13 busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
